jts16_snd_mailbox: RTL and testbench
====================================

// Module: jts16_snd_mailbox
// PURPOSE
//  Sound-CPU end of the main->sound command channel. Receives the command byte
//  (PPI port A) and strobe (PPI port C bit 7, snd_irqn) from the 68000 side.
//  Holds the byte for the Z80, raises the Z80 NMI and returns snd_ack
//  (PPI port C bit 6 input) once the Z80 has consumed the command.
// PARAMETERS
//  NMI_W   16  NMI low-pulse width, clk cycles (>=2)
//  GAP      4  min nmi_n high time between pulses, clk cycles (>=1)
//  QDEPTH   4  FIFO entries, power of 2; used only with JTS16_SNDQ_EN
// PORTS
//  clk        in   1  system clock
//  rstn       in   1  asynchronous active-low reset
//  snd_latch  in   8  command byte from main PPI port A
//  snd_irqn   in   1  command strobe from main PPI port C[7]; falling edge = new command
//  snd_ack    out  1  to main PPI port C[6]; 1 = mailbox empty / ready
//  cs         in   1  Z80 mailbox chip select
//  rd_n       in   1  Z80 read strobe, active low
//  addr0      in   1  0 = data register, 1 = status register
//  dout       out  8  Z80 read data, registered
//  nmi_n      out  1  Z80 NMI, active low
//  pending    out  1  unread command present
// BEHAVIOUR
//  Reset: snd_ack=1, nmi_n=1, dout=8'hFF, pending=0, overrun=0, FSM=IDLE.
//    Held data is cleared to 8'hFF.
//  Reset mid-pulse aborts the pulse. nmi_n returns high asynchronously.
//  Strobe: snd_irqn is registered once. A write event is a 1->0 transition
//    between consecutive samples.
//  Write event: snd_latch is captured in the same cycle. pending=1 on the next
//    cycle. Held low or high levels generate no further events.
//  Z80 access: an access event is the first cycle of cs & ~rd_n. One event per
//    access, regardless of how long the strobe is held.
//  Access effect: dout is loaded on the next cycle and holds until the next access.
//  addr0=0 read: returns the head byte, or 8'hFF if empty.
//    Consumes the head if pending=1.
//  addr0=1 read: returns {pending, overrun, 6'b0}. Clears overrun.
//  snd_ack = ~pending, registered. It rises 1 cycle after the consuming read
//    and falls 1 cycle after the write event.
//  Simultaneous write event and data read in one cycle:
//    - the read returns the old head and consumes it;
//    - the new byte is stored;
//    - pending stays 1 and no overrun is flagged.
//  NMI FSM:
//    IDLE  -> PULSE      when pending=1.
//    PULSE -> WAIT       nmi_n=0 for exactly NMI_W cycles.
//    WAIT  -> GAP        when the head is consumed.
//    GAP   -> IDLE       after GAP cycles with nmi_n=1.
//  A write event during PULSE or WAIT does not restart the pulse.
//  Counters are $clog2 of the parameter width and saturate at terminal count.
// CONFIGURATION
//  JTS16_SNDQ_EN undefined: single-entry mailbox.
//    - A write event while pending=1 overwrites the byte and sets overrun=1.
//  JTS16_SNDQ_EN defined: QDEPTH-entry FIFO, read/write pointers wrap modulo QDEPTH.
//    - pending = not empty.
//    - A write event when full drops the byte and sets overrun=1.
//    - After a consuming read with entries left, the FSM goes GAP -> IDLE -> PULSE,
//      giving one NMI per entry.
// TESTING
//  1 Reset, then leave the bus idle: snd_ack=1, nmi_n=1, pending=0, dout=FF.
//    Status read returns 8'h00.
//  2 snd_latch=8'h5A, then drop snd_irqn:
//    - pending=1 and snd_ack=0;
//    - nmi_n is low for exactly 16 cycles;
//    - data read returns 5A; snd_ack=1 one cycle later;
//    - nmi_n stays high for at least 4 cycles.
//  3 Without the macro, write 11 then 22 with no read:
//    - status reads C0, then the next status read returns 80;
//    - data read returns 22.
//  4 With the macro, write 01, 02, 03, 04, 05:
//    - status shows overrun;
//    - four NMI pulses occur across four reads returning 01, 02, 03, 04;
//    - the fifth read returns FF and pending=0.
//  5 Write event in the same cycle as a data read of 33, new byte 44:
//    - the read returns 33;
//    - pending stays 1 and overrun=0;
//    - the next read returns 44.
//  6 Assert rstn=0 during PULSE:
//    - nmi_n=1 immediately and pending=0;
//    - after release, no NMI occurs until a new snd_irqn falling edge.

Source files
------------

// File: rtl/jts16_snd_mailbox.sv
// jts16_snd_mailbox: sound-CPU end of the main->sound command channel.
// Latches the command byte on each snd_irqn falling edge, presents it to the
// Z80 through a data/status register pair, pulses NMI and returns snd_ack.
// Build option: define JTS16_SNDQ_EN to replace the single-entry mailbox with
// a QDEPTH-entry FIFO (QDEPTH only exists in that build).
module jts16_snd_mailbox #(
  parameter int unsigned NMI_W  = 16,
  parameter int unsigned GAP    = 4
`ifdef JTS16_SNDQ_EN
  , parameter int unsigned QDEPTH = 4
`endif
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] snd_latch,
  input  logic       snd_irqn,
  output logic       snd_ack,
  input  logic       cs,
  input  logic       rd_n,
  input  logic       addr0,
  output logic [7:0] dout,
  output logic       nmi_n,
  output logic       pending
);

  localparam int unsigned NW = (NMI_W > 1) ? $clog2(NMI_W) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned CW = (NW > GW) ? NW : GW;

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT, ST_GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          served;
  logic          irqn_q;
  logic          acc_q;
  logic          overrun;
  logic          wr_ev;
  logic          acc_ev;
  logic          rd_data;
  logic          rd_stat;
  logic          consume;
  logic          ovr_set;
  logic          pending_nx;
  logic [7:0]    head;

  // Edge detection: one write per strobe fall, one access per Z80 read strobe
  assign wr_ev   = irqn_q & ~snd_irqn;
  assign acc_ev  = cs & ~rd_n & ~acc_q;
  assign rd_data = acc_ev & ~addr0;
  assign rd_stat = acc_ev & addr0;
  assign consume = rd_data & pending;

`ifdef JTS16_SNDQ_EN
  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [7:0]  mem [QDEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   fill;
  logic [AW:0]   fill_nx;
  logic          full;
  logic          push;

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign full    = (fill == (AW+1)'(QDEPTH));
  assign push    = wr_ev & (~full | consume);
  assign ovr_set = wr_ev & full & ~consume;
  assign head    = mem[rp];

  // Occupancy after this cycle's push/pop
  always_comb begin
    fill_nx = fill;
    if (push && !consume)      fill_nx = fill + (AW+1)'(1);
    else if (!push && consume) fill_nx = fill - (AW+1)'(1);
  end

  assign pending_nx = (fill_nx != '0);

  // FIFO storage and pointers; pointers wrap naturally at QDEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= '0;
      rp   <= '0;
      fill <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) mem[i] <= 8'hFF;
    end else begin
      if (push) begin
        mem[wp] <= snd_latch;
        wp      <= wp + AW'(1);
      end
      if (consume) rp <= rp + AW'(1);
      fill <= fill_nx;
    end
  end
`else
  logic [7:0] hold;

  // Single entry: a new byte overwrites an unread one unless it is read now
  assign head       = hold;
  assign ovr_set    = wr_ev & pending & ~consume;
  assign pending_nx = wr_ev | (pending & ~consume);

  // Mailbox byte register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      hold <= 8'hFF;
    else if (wr_ev) hold <= snd_latch;
  end
`endif

  // Strobe sampling, flags, handshake and Z80 read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqn_q  <= 1'b0;
      acc_q   <= 1'b0;
      pending <= 1'b0;
      snd_ack <= 1'b1;
      overrun <= 1'b0;
      dout    <= 8'hFF;
    end else begin
      irqn_q  <= snd_irqn;
      acc_q   <= cs & ~rd_n;
      pending <= pending_nx;
      snd_ack <= ~pending_nx;
      overrun <= ovr_set | (overrun & ~rd_stat);
      if (rd_stat)      dout <= {pending, overrun, 6'b0};
      else if (rd_data) dout <= pending ? head : 8'hFF;
    end
  end

  // NMI sequencer: fixed-width pulse, wait for the head to go, enforce a gap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      nmi_n  <= 1'b1;
      cnt    <= '0;
      served <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) begin
            state  <= ST_PULSE;
            nmi_n  <= 1'b0;
            cnt    <= '0;
            served <= consume;
          end
        end
        ST_PULSE: begin
          if (consume) served <= 1'b1;
          if (cnt == CW'(NMI_W - 1)) begin
            state <= ST_WAIT;
            nmi_n <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (consume || served) begin
            state <= ST_GAP;
            cnt   <= '0;
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) state <= ST_IDLE;
          else                     cnt   <= cnt + CW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jts16_snd_mailbox.sv
// Bench for jts16_snd_mailbox: directed vector table, hand-written NMI/reset
// sequences and a randomized run against a queue-based reference model.
module tb_jts16_snd_mailbox;

  localparam int NMI_W_TB = 16;
  localparam int GAP_TB   = 4;
`ifdef JTS16_SNDQ_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk;
  logic       rstn;
  logic [7:0] snd_latch;
  logic       snd_irqn;
  logic       snd_ack;
  logic       cs;
  logic       rd_n;
  logic       addr0;
  logic [7:0] dout;
  logic       nmi_n;
  logic       pending;

  jts16_snd_mailbox dut (
    .clk       (clk),
    .rstn      (rstn),
    .snd_latch (snd_latch),
    .snd_irqn  (snd_irqn),
    .snd_ack   (snd_ack),
    .cs        (cs),
    .rd_n      (rd_n),
    .addr0     (addr0),
    .dout      (dout),
    .nmi_n     (nmi_n),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] q[$];
  logic       m_ovr;
  logic [7:0] m_dout;
  logic       m_prev_irqn;
  logic       m_prev_acc;
  logic       pend_before;

  // NMI monitor state
  logic prev_nmi;
  int   low_run;
  int   high_run;
  int   pulse_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr       = 1'b0;
    m_dout      = 8'hFF;
    m_prev_irqn = 1'b0;
    m_prev_acc  = 1'b0;
  endtask

  // One clock of the mailbox seen as a byte queue with an overrun flag
  task automatic model_step();
    logic wr, acc, clr, set;
    wr  = m_prev_irqn & ~snd_irqn;
    acc = cs & ~rd_n & ~m_prev_acc;
    m_prev_irqn = snd_irqn;
    m_prev_acc  = cs & ~rd_n;
    clr = 1'b0;
    set = 1'b0;
    if (acc) begin
      if (addr0) begin
        m_dout = {q.size() != 0, m_ovr, 6'b0};
        clr = 1'b1;
      end else if (q.size() != 0) begin
        m_dout = q.pop_front();
      end else begin
        m_dout = 8'hFF;
      end
    end
    if (wr) begin
      if (q.size() < DEPTH) q.push_back(snd_latch);
      else begin
        set = 1'b1;
        if (DEPTH == 1) q[0] = snd_latch;
      end
    end
    m_ovr = set | (m_ovr & ~clr);
  endtask

  // Advance one clock, update the model and compare outputs
  task automatic cyc();
    pend_before = (q.size() != 0);
    if (!rstn) model_reset();
    else       model_step();
    @(posedge clk);
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("pending", 32'(pending), 32'(q.size() != 0));
    chk("snd_ack", 32'(snd_ack), 32'(q.size() == 0));
    if (!rstn) begin
      prev_nmi = 1'b1;
      low_run  = 0;
      high_run = GAP_TB;
    end else begin
      if (!nmi_n) begin
        if (prev_nmi) begin
          chk("nmi_gap", 32'(high_run >= GAP_TB), 32'd1);
          chk("nmi_cause", 32'(pend_before), 32'd1);
          pulse_cnt++;
          low_run = 0;
        end
        low_run++;
      end else begin
        if (!prev_nmi) begin
          chk("nmi_width", 32'(low_run), 32'(NMI_W_TB));
          high_run = 0;
        end
        high_run++;
      end
      prev_nmi = nmi_n;
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    snd_latch = b;
    snd_irqn  = 1'b0;
    cyc();
    snd_irqn  = 1'b1;
    cyc();
  endtask

  // Strobe held for two cycles: still only one access
  task automatic do_read(input logic a);
    cs = 1'b1; rd_n = 1'b0; addr0 = a;
    cyc();
    cyc();
    cs = 1'b0; rd_n = 1'b1;
    cyc();
  endtask

  task automatic do_both(input logic [7:0] b);
    snd_latch = b;
    snd_irqn  = 1'b0;
    cs = 1'b1; rd_n = 1'b0; addr0 = 1'b0;
    cyc();
    snd_irqn = 1'b1;
    cs = 1'b0; rd_n = 1'b1;
    cyc();
  endtask

  typedef enum int {OP_W, OP_RD, OP_RS, OP_BOTH} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [7:0] exp_dout;
    logic       exp_pend;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic hi_ok;
    int   lowc;
    int   pc0;

    // directed vectors: {op, byte, expected dout, expected pending}
    tbl.push_back('{OP_RS,   8'h00, 8'h00, 1'b0});
    tbl.push_back('{OP_RD,   8'h00, 8'hFF, 1'b0});
    tbl.push_back('{OP_W,    8'h33, 8'hFF, 1'b1});
    tbl.push_back('{OP_BOTH, 8'h44, 8'h33, 1'b1});
    tbl.push_back('{OP_RS,   8'h00, 8'h80, 1'b1});
    tbl.push_back('{OP_RD,   8'h00, 8'h44, 1'b0});
    tbl.push_back('{OP_RD,   8'h00, 8'hFF, 1'b0});
`ifndef JTS16_SNDQ_EN
    tbl.push_back('{OP_W,    8'h11, 8'hFF, 1'b1});
    tbl.push_back('{OP_W,    8'h22, 8'hFF, 1'b1});
    tbl.push_back('{OP_RS,   8'h00, 8'hC0, 1'b1});
    tbl.push_back('{OP_RS,   8'h00, 8'h80, 1'b1});
    tbl.push_back('{OP_RD,   8'h00, 8'h22, 1'b0});
    tbl.push_back('{OP_RD,   8'h00, 8'hFF, 1'b0});
`endif

    snd_latch = 8'h00; snd_irqn = 1'b1;
    cs = 1'b0; rd_n = 1'b1; addr0 = 1'b0;
    rstn = 1'b0;
    model_reset();
    prev_nmi = 1'b1; low_run = 0; high_run = GAP_TB; pulse_cnt = 0;

    repeat (3) cyc();
    rstn = 1'b1;
    repeat (5) cyc();
    chk("rst_ack", 32'(snd_ack), 32'd1);
    chk("rst_nmi", 32'(nmi_n), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dout", 32'(dout), 32'hFF);

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_W:    do_write(tbl[i].data);
        OP_RD:   do_read(1'b0);
        OP_RS:   do_read(1'b1);
        default: do_both(tbl[i].data);
      endcase
      chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].exp_pend));
    end

    // single command: pulse width, read, handshake, gap
    repeat (30) cyc();
    snd_latch = 8'h5A; snd_irqn = 1'b0;
    cyc();
    chk("t2_pending", 32'(pending), 32'd1);
    chk("t2_ack", 32'(snd_ack), 32'd0);
    snd_irqn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (!nmi_n) found = 1'b1;
    end
    chk("t2_nmi_seen", 32'(found), 32'd1);
    lowc = 0;
    while (!nmi_n && lowc < 40) begin
      lowc++;
      cyc();
    end
    chk("t2_nmi_width", 32'(lowc), 32'(NMI_W_TB));
    cs = 1'b1; rd_n = 1'b0; addr0 = 1'b0;
    cyc();
    cs = 1'b0; rd_n = 1'b1;
    chk("t2_dout", 32'(dout), 32'h5A);
    chk("t2_ack_after", 32'(snd_ack), 32'd1);
    hi_ok = 1'b1;
    repeat (GAP_TB) begin
      cyc();
      if (!nmi_n) hi_ok = 1'b0;
    end
    chk("t2_nmi_high", 32'(hi_ok), 32'd1);
    repeat (20) cyc();

`ifdef JTS16_SNDQ_EN
    // FIFO: five writes into four entries, one NMI per entry
    pc0 = pulse_cnt;
    for (int i = 1; i <= 5; i++) do_write(8'(i));
    do_read(1'b1);
    chk("t4_status", 32'(dout), 32'hC0);
    for (int i = 0; i < 4; i++) begin
      int waited;
      waited = 0;
      while (!(pulse_cnt >= pc0 + i + 1 && nmi_n) && waited < 80) begin
        cyc();
        waited++;
      end
      chk($sformatf("t4_pulse%0d", i), 32'(pulse_cnt >= pc0 + i + 1), 32'd1);
      do_read(1'b0);
      chk($sformatf("t4_read%0d", i), 32'(dout), 32'(i + 1));
    end
    do_read(1'b0);
    chk("t4_read_empty", 32'(dout), 32'hFF);
    chk("t4_pending", 32'(pending), 32'd0);
    repeat (40) cyc();
    chk("t4_pulses", 32'(pulse_cnt - pc0), 32'd4);
`endif

    // reset in the middle of a pulse, strobe still held low
    snd_latch = 8'h77; snd_irqn = 1'b0;
    cyc();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (!nmi_n) found = 1'b1;
    end
    chk("t6_nmi_seen", 32'(found), 32'd1);
    repeat (3) cyc();
    rstn = 1'b0;
    #1;
    chk("t6_nmi_async", 32'(nmi_n), 32'd1);
    chk("t6_pending_async", 32'(pending), 32'd0);
    model_reset();
    repeat (2) cyc();
    rstn = 1'b1;
    pc0 = pulse_cnt;
    repeat (40) cyc();
    chk("t6_no_nmi", 32'(pulse_cnt - pc0), 32'd0);
    chk("t6_pending_idle", 32'(pending), 32'd0);
    snd_irqn = 1'b1;
    cyc();
    snd_irqn = 1'b0;
    cyc();
    snd_irqn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      if (!nmi_n) found = 1'b1;
    end
    chk("t6_nmi_new_edge", 32'(found), 32'd1);
    lowc = 0;
    while (!nmi_n && lowc < 40) begin
      lowc++;
      cyc();
    end
    do_read(1'b0);
    chk("t6_dout", 32'(dout), 32'h77);
    repeat (20) cyc();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rstn      = ($urandom_range(0, 399) != 0);
      snd_latch = 8'($urandom_range(0, 255));
      snd_irqn  = ($urandom_range(0, 2) != 0);
      cs        = 1'($urandom_range(0, 1));
      rd_n      = ($urandom_range(0, 2) != 0);
      addr0     = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rstn = 1'b1; cs = 1'b0; rd_n = 1'b1; snd_irqn = 1'b1;
    repeat (10) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
